tank_motion: RTL and testbench
==============================

Name: tank_motion

Overview:
Parametrised per-frame tank controller for the game datapath. Decodes the keyboard keycode into movement with a speed ramp and clamps the tank to the playfield. Generates a one-frame fire pulse with a cooldown and a muzzle position. Outputs feed the sprite renderer and the projectile spawner.

Parameters:
W, 10, bit width of all position ports and arithmetic
X_MIN / X_MAX, 0 / 640, playfield horizontal bounds; tank occupies [TankX, TankX+TANK_W)
Y_MIN / Y_MAX, 0 / 480, playfield vertical bounds; tank occupies [TankY, TankY+TANK_H)
TANK_W / TANK_H, 32 / 16, sprite size in pixels
X_INIT / Y_INIT, 304 / 440, reset position; must lie inside the clamp range
MIN_STEP / MAX_STEP, 1 / 4, starting and ceiling pixels per frame
RAMP_FRAMES, 8, held frames per step increment (>=1)
COOLDOWN_FRAMES, 30, frames after a shot during which fire is ignored
VERTICAL_EN, 0, 1 enables W/S vertical movement
KEY_LEFT / KEY_RIGHT / KEY_UP / KEY_DOWN / KEY_FIRE, 8'h04 / 8'h07 / 8'h1A / 8'h16 / 8'h2C, HID codes

Ports:
frame_clk  in  1  frame-rate clock; every update happens on its rising edge
Reset_n  in  1  asynchronous, active-low reset
keycode  in  8  current key; 8'h00 = none
TankX  out  W  registered top-left X
TankY  out  W  registered top-left Y
Dir  out  2  last movement direction: 0 right, 1 left, 2 up, 3 down
Moving  out  1  direction key acted on this frame
AtEdge  out  1  tank at any clamp bound
Fire  out  1  one-frame shot pulse
ShotX / ShotY  out  W  muzzle position, valid when Fire=1

Behaviour:
- Reset (Reset_n=0, async): TankX=X_INIT, TankY=Y_INIT, Dir=0, Moving=0, Fire=0, ShotX=ShotY=0, AtEdge per reset position, state IDLE, step=MIN_STEP, hold cnt=0, cooldown=0, fire_prev=0. Deasserting Reset_n mid-motion restarts from these values. No partial update.
- Latency: keycode sampled at edge k. Every output reflects it after edge k. All outputs are registered.
- Direction keys: LEFT/RIGHT always active. UP/DOWN act only if VERTICAL_EN=1; otherwise they are treated as no key. Any other code is treated as no key.
- FSM states: IDLE, ACCEL, CRUISE.
  - IDLE + dir key -> ACCEL, with step=MIN_STEP, cnt=0, Dir=key dir.
  - ACCEL + same key: move by step, cnt++. When cnt reaches RAMP_FRAMES: cnt=0, step++. When step reaches MAX_STEP -> CRUISE.
  - CRUISE + same key: move by MAX_STEP.
  - ACCEL/CRUISE + different dir key -> ACCEL with the new Dir, step=MIN_STEP, and the move happens the same frame.
  - Any state + no dir key -> IDLE, no move, Moving=0.
  - If MIN_STEP==MAX_STEP, ACCEL goes directly to CRUISE.
- Resulting step for the n-th consecutive held frame: min(MIN_STEP + floor((n-1)/RAMP_FRAMES), MAX_STEP).
- Clamp: arithmetic in W+1 bits with no wrap.
  - Right: X = min(X+step, X_MAX-TANK_W). Left: X = (X < X_MIN+step) ? X_MIN : X-step. Y uses the same rules with Y_MIN and Y_MAX-TANK_H.
  - A clamp does not change FSM state. Moving stays 1.
- AtEdge=1 when TankX is X_MIN or X_MAX-TANK_W. If VERTICAL_EN=1, it is also 1 when TankY is Y_MIN or Y_MAX-TANK_H.
- Fire: when keycode==KEY_FIRE, fire_prev=0 and cooldown==0:
  - Fire=1 for that frame. ShotX=TankX+TANK_W/2 and ShotY=TankY-1 (saturating at 0), both taken from the pre-update position.
  - cooldown loads COOLDOWN_FRAMES.
- Cooldown decrements once per frame down to 0. A fire press while cooldown>0 or while the key is still held is ignored, with no queuing. fire_prev tracks keycode==KEY_FIRE.
- A fire frame carries no direction key, so the FSM goes to IDLE.

Test Plan:
1. Reset_n=0 -> TankX=304, TankY=440, Fire=0, Moving=0, Dir=0; release with keycode=00 for 5 frames -> outputs unchanged.
2. RAMP_FRAMES=4, MAX_STEP=3; hold 07 for 10 frames from X=304 -> X sequence 305..308, 310..316, 319, 322; Moving=1 throughout.
3. X_INIT=604; hold 07 -> 605, 606, 607, 608, then 608 on every later frame; AtEdge=1 from frame 4; left clamp mirrors this at X_MIN=0.
4. Hold 07 for 9 frames (step 2), then 04 -> first left move is 1 px, Dir=1; then keycode=00 -> IDLE, Moving=0, X frozen.
5. Tap 2C at X=304 -> Fire=1 for one frame, ShotX=320, ShotY=439. Hold 2C for 5 frames -> single pulse. Re-tap at frame 20 -> ignored; re-tap at frame 31 -> pulse.
6. VERTICAL_EN=1: hold 1A -> Y decreases, Dir=2. Reset_n pulsed low mid-ramp -> immediate return to 304/440, step back to MIN_STEP on the next press.

Source files
------------

// File: rtl/tank_motion.sv
// tank_motion: per-frame tank controller for the game datapath.
//   Decodes the keyboard keycode into a direction with a speed ramp
//   (IDLE -> ACCEL -> CRUISE) and clamps the tank to the playfield.
//   It also produces a one-frame fire pulse, gated by a cooldown and by
//   fire-key edge detection, together with the muzzle position.
//
// Ports:
//   frame_clk  in   1  frame-rate clock, all updates on its rising edge
//   Reset_n    in   1  asynchronous active-low reset
//   keycode    in   8  current HID keycode, 8'h00 = none
//   TankX      out  W  registered top-left X
//   TankY      out  W  registered top-left Y
//   Dir        out  2  last movement direction (0 R, 1 L, 2 U, 3 D)
//   Moving     out  1  a direction key was acted on this frame
//   AtEdge     out  1  tank sits on a clamp bound
//   Fire       out  1  one-frame shot pulse
//   ShotX      out  W  muzzle X, valid when Fire=1
//   ShotY      out  W  muzzle Y, valid when Fire=1
module tank_motion #(
    parameter int         W               = 10,
    parameter int         X_MIN           = 0,
    parameter int         X_MAX           = 640,
    parameter int         Y_MIN           = 0,
    parameter int         Y_MAX           = 480,
    parameter int         TANK_W          = 32,
    parameter int         TANK_H          = 16,
    parameter int         X_INIT          = 304,
    parameter int         Y_INIT          = 440,
    parameter int         MIN_STEP        = 1,
    parameter int         MAX_STEP        = 4,
    parameter int         RAMP_FRAMES     = 8,
    parameter int         COOLDOWN_FRAMES = 30,
    parameter int         VERTICAL_EN     = 0,
    parameter logic [7:0] KEY_LEFT        = 8'h04,
    parameter logic [7:0] KEY_RIGHT       = 8'h07,
    parameter logic [7:0] KEY_UP          = 8'h1A,
    parameter logic [7:0] KEY_DOWN        = 8'h16,
    parameter logic [7:0] KEY_FIRE        = 8'h2C
) (
    input  logic         frame_clk,
    input  logic         Reset_n,
    input  logic [7:0]   keycode,
    output logic [W-1:0] TankX,
    output logic [W-1:0] TankY,
    output logic [1:0]   Dir,
    output logic         Moving,
    output logic         AtEdge,
    output logic         Fire,
    output logic [W-1:0] ShotX,
    output logic [W-1:0] ShotY
);

    localparam int CW = (RAMP_FRAMES < 2) ? 1 : $clog2(RAMP_FRAMES + 1);
    localparam int DW = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

    // Bounds carried in W+1 bits so that pos+step never wraps.
    localparam logic [W:0]    X_LO   = (W+1)'(X_MIN);
    localparam logic [W:0]    X_HI   = (W+1)'(X_MAX - TANK_W);
    localparam logic [W:0]    Y_LO   = (W+1)'(Y_MIN);
    localparam logic [W:0]    Y_HI   = (W+1)'(Y_MAX - TANK_H);
    localparam logic [W-1:0]  MIN_S  = W'(MIN_STEP);
    localparam logic [W-1:0]  MAX_S  = W'(MAX_STEP);
    localparam logic [W-1:0]  X_RST  = W'(X_INIT);
    localparam logic [W-1:0]  Y_RST  = W'(Y_INIT);
    localparam logic [W-1:0]  HALF_W = W'(TANK_W / 2);
    localparam logic [CW-1:0] RAMP_C = CW'(RAMP_FRAMES);
    localparam logic [DW-1:0] COOL_C = DW'(COOLDOWN_FRAMES);
    localparam logic          EDGE_RST =
        (X_INIT == X_MIN) || (X_INIT == X_MAX - TANK_W) ||
        ((VERTICAL_EN != 0) && ((Y_INIT == Y_MIN) || (Y_INIT == Y_MAX - TANK_H)));

    typedef enum logic [1:0] {IDLE, ACCEL, CRUISE} state_t;

    state_t         state_q, state_next;
    logic [W-1:0]   step_q, step_next, cur_step;
    logic [CW-1:0]  cnt_q, cnt_next, cnt_inc;
    logic [DW-1:0]  cool_q, cool_next;
    logic           fire_prev_q;

    logic           dir_valid, fresh, fire_go;
    logic [1:0]     key_dir, dir_next;
    logic [W-1:0]   x_next, y_next, shot_x_next, shot_y_next;
    logic           moving_next, at_edge_next;

    // Move one axis by step toward hi (up=1) or lo (up=0), clamped.
    function automatic logic [W-1:0] advance(input logic [W-1:0] pos,
                                             input logic [W-1:0] step,
                                             input logic         up,
                                             input logic [W:0]   lo,
                                             input logic [W:0]   hi);
        logic [W:0] p;
        logic [W:0] s;
        logic [W:0] r;
        p = {1'b0, pos};
        s = {1'b0, step};
        if (up) begin
            r = p + s;
            if (r > hi) r = hi;
        end else begin
            r = (p < lo + s) ? lo : p - s;
        end
        return r[W-1:0];
    endfunction

    // Keycode decode; vertical codes fall through to "no key" when disabled.
    always_comb begin
        dir_valid = 1'b0;
        key_dir   = 2'd0;
        if (keycode == KEY_RIGHT) begin
            dir_valid = 1'b1;
            key_dir   = 2'd0;
        end else if (keycode == KEY_LEFT) begin
            dir_valid = 1'b1;
            key_dir   = 2'd1;
        end else if ((VERTICAL_EN != 0) && (keycode == KEY_UP)) begin
            dir_valid = 1'b1;
            key_dir   = 2'd2;
        end else if ((VERTICAL_EN != 0) && (keycode == KEY_DOWN)) begin
            dir_valid = 1'b1;
            key_dir   = 2'd3;
        end
    end

    // State register (all state and registered outputs).
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            step_q      <= MIN_S;
            cnt_q       <= '0;
            cool_q      <= '0;
            fire_prev_q <= 1'b0;
            TankX       <= X_RST;
            TankY       <= Y_RST;
            Dir         <= 2'd0;
            Moving      <= 1'b0;
            AtEdge      <= EDGE_RST;
            Fire        <= 1'b0;
            ShotX       <= '0;
            ShotY       <= '0;
        end else begin
            state_q     <= state_next;
            step_q      <= step_next;
            cnt_q       <= cnt_next;
            cool_q      <= cool_next;
            fire_prev_q <= (keycode == KEY_FIRE);
            TankX       <= x_next;
            TankY       <= y_next;
            Dir         <= dir_next;
            Moving      <= moving_next;
            AtEdge      <= at_edge_next;
            Fire        <= fire_go;
            ShotX       <= shot_x_next;
            ShotY       <= shot_y_next;
        end
    end

    // Next-state logic. A "fresh" press (from IDLE or a direction change)
    // restarts the ramp and still moves by MIN_STEP in the same frame, so
    // the n-th held frame moves by min(MIN + (n-1)/RAMP, MAX).
    always_comb begin
        state_next = IDLE;
        step_next  = MIN_S;
        cnt_next   = '0;
        cur_step   = MIN_S;
        cnt_inc    = '0;
        fresh      = (state_q == IDLE) || (key_dir != Dir);
        if (dir_valid) begin
            if (!fresh && (state_q == CRUISE)) begin
                state_next = CRUISE;
                step_next  = MAX_S;
                cur_step   = MAX_S;
            end else begin
                cur_step = fresh ? MIN_S : step_q;
                cnt_inc  = (fresh ? '0 : cnt_q) + CW'(1);
                if (cur_step >= MAX_S) begin
                    state_next = CRUISE;
                    step_next  = MAX_S;
                end else if (cnt_inc == RAMP_C) begin
                    step_next  = cur_step + W'(1);
                    state_next = (step_next >= MAX_S) ? CRUISE : ACCEL;
                end else begin
                    cnt_next   = cnt_inc;
                    step_next  = cur_step;
                    state_next = ACCEL;
                end
            end
        end
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        x_next      = TankX;
        y_next      = TankY;
        dir_next    = Dir;
        moving_next = dir_valid;
        if (dir_valid) begin
            dir_next = key_dir;
            case (key_dir)
                2'd0:    x_next = advance(TankX, cur_step, 1'b1, X_LO, X_HI);
                2'd1:    x_next = advance(TankX, cur_step, 1'b0, X_LO, X_HI);
                2'd2:    y_next = advance(TankY, cur_step, 1'b0, Y_LO, Y_HI);
                default: y_next = advance(TankY, cur_step, 1'b1, Y_LO, Y_HI);
            endcase
        end

        // Rising edge of the fire key only, and only once the cooldown expired.
        fire_go     = (keycode == KEY_FIRE) && !fire_prev_q && (cool_q == '0);
        shot_x_next = fire_go ? TankX + HALF_W : ShotX;
        shot_y_next = ShotY;
        if (fire_go) begin
            shot_y_next = (TankY == '0) ? '0 : TankY - W'(1);
        end
        if (fire_go) begin
            cool_next = COOL_C;
        end else if (cool_q != '0) begin
            cool_next = cool_q - DW'(1);
        end else begin
            cool_next = '0;
        end

        at_edge_next = (x_next == X_LO[W-1:0]) || (x_next == X_HI[W-1:0]) ||
                       ((VERTICAL_EN != 0) &&
                        ((y_next == Y_LO[W-1:0]) || (y_next == Y_HI[W-1:0])));
    end

endmodule

// File: tb/tb_tank_motion.sv
// Bench for tank_motion: four instances with different parameter sets,
// driven from a table of {instance, keycode, expected outputs} records.
module tb_tank_motion;

    logic       frame_clk = 1'b0;
    logic       rst_n;
    logic [7:0] key    [4];
    logic [9:0] tx     [4];
    logic [9:0] ty     [4];
    logic [9:0] sx     [4];
    logic [9:0] sy     [4];
    logic [1:0] dir    [4];
    logic       mov    [4];
    logic       edg    [4];
    logic       fire   [4];

    int checks = 0;
    int errors = 0;

    always #5 frame_clk = ~frame_clk;

    // 0: defaults
    tank_motion u_a (
        .frame_clk(frame_clk), .Reset_n(rst_n), .keycode(key[0]),
        .TankX(tx[0]), .TankY(ty[0]), .Dir(dir[0]), .Moving(mov[0]),
        .AtEdge(edg[0]), .Fire(fire[0]), .ShotX(sx[0]), .ShotY(sy[0])
    );
    // 1: short ramp, vertical enabled
    tank_motion #(.RAMP_FRAMES(4), .MAX_STEP(3), .VERTICAL_EN(1)) u_b (
        .frame_clk(frame_clk), .Reset_n(rst_n), .keycode(key[1]),
        .TankX(tx[1]), .TankY(ty[1]), .Dir(dir[1]), .Moving(mov[1]),
        .AtEdge(edg[1]), .Fire(fire[1]), .ShotX(sx[1]), .ShotY(sy[1])
    );
    // 2: starts near the right bound
    tank_motion #(.X_INIT(604)) u_c (
        .frame_clk(frame_clk), .Reset_n(rst_n), .keycode(key[2]),
        .TankX(tx[2]), .TankY(ty[2]), .Dir(dir[2]), .Moving(mov[2]),
        .AtEdge(edg[2]), .Fire(fire[2]), .ShotX(sx[2]), .ShotY(sy[2])
    );
    // 3: starts near the left bound
    tank_motion #(.X_INIT(4)) u_d (
        .frame_clk(frame_clk), .Reset_n(rst_n), .keycode(key[3]),
        .TankX(tx[3]), .TankY(ty[3]), .Dir(dir[3]), .Moving(mov[3]),
        .AtEdge(edg[3]), .Fire(fire[3]), .ShotX(sx[3]), .ShotY(sy[3])
    );

    typedef struct {
        int         id;
        int         inst;
        logic [7:0] k;
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] d;
        logic       m;
        logic       e;
        logic       f;
        logic [9:0] sxv;
        logic [9:0] syv;
        bit         cs;   // compare shot position
        bit         chk;  // frame is checked
    } vec_t;

    vec_t vecs  [$];
    vec_t exp_q [$];

    function automatic void add(int inst, logic [7:0] k, int x, int y, int d,
                                bit m, bit e, bit f, int sxv, int syv, bit chk);
        vec_t v;
        v.id   = vecs.size();
        v.inst = inst;
        v.k    = k;
        v.x    = 10'(x);
        v.y    = 10'(y);
        v.d    = 2'(d);
        v.m    = m;
        v.e    = e;
        v.f    = f;
        v.sxv  = 10'(sxv);
        v.syv  = 10'(syv);
        v.cs   = f;
        v.chk  = chk;
        vecs.push_back(v);
    endfunction

    task automatic check_one(input string nm, input vec_t v);
        int  i;
        bit  ok;
        i  = v.inst;
        ok = (tx[i] == v.x) && (ty[i] == v.y) && (dir[i] == v.d) &&
             (mov[i] == v.m) && (edg[i] == v.e) && (fire[i] == v.f) &&
             (!v.cs || ((sx[i] == v.sxv) && (sy[i] == v.syv)));
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s#%0d inst%0d: got x=%0d y=%0d dir=%0d mov=%0b edge=%0b fire=%0b sx=%0d sy=%0d; want x=%0d y=%0d dir=%0d mov=%0b edge=%0b fire=%0b sx=%0d sy=%0d",
                     nm, v.id, i, tx[i], ty[i], dir[i], mov[i], edg[i], fire[i], sx[i], sy[i],
                     v.x, v.y, v.d, v.m, v.e, v.f, v.sxv, v.syv);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge frame_clk);
        for (int i = 0; i < 4; i++) key[i] = 8'h00;
        key[v.inst] = v.k;
        if (v.chk) exp_q.push_back(v);
        @(posedge frame_clk);
        #1;
        if (v.chk) check_one("vec", exp_q.pop_front());
    endtask

    task automatic hand_check(input string nm, input int inst, input int x, input int y,
                              input int d, input bit m, input bit e);
        vec_t v;
        v.id = -1; v.inst = inst; v.k = 8'h00;
        v.x = 10'(x); v.y = 10'(y); v.d = 2'(d); v.m = m; v.e = e; v.f = 1'b0;
        v.sxv = '0; v.syv = '0; v.cs = 1'b1; v.chk = 1'b1;
        check_one(nm, v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int xs_b [10] = '{305, 306, 307, 308, 310, 312, 314, 316, 319, 322};
        int xs_c [6]  = '{605, 606, 607, 608, 608, 608};
        int xs_d [6]  = '{3, 2, 1, 0, 0, 0};
        int xs_a [9]  = '{305, 306, 307, 308, 309, 310, 311, 312, 314};
        int xs_r [6]  = '{323, 324, 325, 326, 328, 330};

        // ---- table ----
        for (int i = 0; i < 5; i++) add(0, 8'h00, 304, 440, 0, 0, 0, 0, 0, 0, 1);
        // fire: tap, cooldown window, re-tap, long hold, release and re-tap
        add(0, 8'h2C, 304, 440, 0, 0, 0, 1, 320, 439, 1);
        for (int j = 1; j <= 66; j++) begin
            if (j == 20)      add(0, 8'h2C, 304, 440, 0, 0, 0, 0, 0, 0, 1);
            else if (j == 31) add(0, 8'h2C, 304, 440, 0, 0, 0, 1, 320, 439, 1);
            else if (j >= 32 && j <= 64) add(0, 8'h2C, 304, 440, 0, 0, 0, 0, 0, 0, 1);
            else if (j == 66) add(0, 8'h2C, 304, 440, 0, 0, 0, 1, 320, 439, 1);
            else              add(0, 8'h00, 304, 440, 0, 0, 0, 0, 0, 0, 1);
        end
        // ramp then direction reversal, idle, ignored codes
        for (int i = 0; i < 9; i++) add(0, 8'h07, xs_a[i], 440, 0, 1, 0, 0, 0, 0, 1);
        add(0, 8'h04, 313, 440, 1, 1, 0, 0, 0, 0, 1);
        add(0, 8'h00, 313, 440, 1, 0, 0, 0, 0, 0, 1);
        add(0, 8'h00, 313, 440, 1, 0, 0, 0, 0, 0, 1);
        add(0, 8'h1A, 313, 440, 1, 0, 0, 0, 0, 0, 1);
        add(0, 8'h55, 313, 440, 1, 0, 0, 0, 0, 0, 1);
        // short ramp
        for (int i = 0; i < 10; i++) add(1, 8'h07, xs_b[i], 440, 0, 1, 0, 0, 0, 0, 1);
        add(1, 8'h00, 322, 440, 0, 0, 0, 0, 0, 0, 1);
        // drive to the top bound, then fire with ShotY saturating
        for (int i = 0; i < 200; i++) add(1, 8'h1A, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h1A, 322, 0, 2, 1, 1, 0, 0, 0, 1);
        add(1, 8'h00, 322, 0, 2, 0, 1, 0, 0, 0, 1);
        add(1, 8'h2C, 322, 0, 2, 0, 1, 1, 338, 0, 1);
        for (int i = 0; i < 6; i++) add(1, 8'h07, xs_r[i], 0, 0, 1, 1, 0, 0, 0, 1);
        // right and left clamps
        for (int i = 0; i < 6; i++) add(2, 8'h07, xs_c[i], 440, 0, 1, (i >= 3), 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) add(3, 8'h04, xs_d[i], 440, 1, 1, (i >= 3), 0, 0, 0, 1);
        add(3, 8'h07, 1, 440, 0, 1, 0, 0, 0, 0, 1);

        // ---- reset ----
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) key[i] = 8'h00;
        repeat (2) @(posedge frame_clk);
        #1;
        hand_check("reset_a", 0, 304, 440, 0, 0, 0);
        hand_check("reset_c", 2, 604, 440, 0, 0, 0);
        @(negedge frame_clk);
        rst_n = 1'b1;

        // B's right-moving ramp is left at step 2 by the last B records,
        // but C/D run in between; the reset sequence below uses fresh frames.
        foreach (vecs[n]) apply(vecs[n]);

        // ---- asynchronous reset mid-ramp on B ----
        for (int i = 0; i < 3; i++) begin
            vec_t v;
            v.id = 1000 + i; v.inst = 1; v.k = 8'h07;
            v.x = 10'(1 + i); v.y = 10'd0; v.d = 2'd0; v.m = 1'b1; v.e = 1'b0; v.f = 1'b0;
            v.sxv = '0; v.syv = '0; v.cs = 1'b0; v.chk = 1'b0;
            apply(v);
        end
        @(negedge frame_clk);
        for (int i = 0; i < 4; i++) key[i] = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        hand_check("async_rst_b", 1, 304, 440, 0, 0, 0);
        @(posedge frame_clk);
        @(negedge frame_clk);
        rst_n = 1'b1;
        begin
            vec_t v;
            v.id = 2000; v.inst = 1; v.k = 8'h07;
            v.x = 10'd305; v.y = 10'd440; v.d = 2'd0; v.m = 1'b1; v.e = 1'b0; v.f = 1'b0;
            v.sxv = '0; v.syv = '0; v.cs = 1'b0; v.chk = 1'b1;
            apply(v);
            v.id = 2001; v.k = 8'h1A; v.y = 10'd439; v.d = 2'd2;
            apply(v);
        end

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
